wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writer-side companion to the CPU register file. Merges single-cycle ALU results with long-latency results (load/mul/div) into the register file's single write port (wb_e, w_baddr, wb_data).
- Long-latency results are buffered in a small FIFO.
- A pending-register scoreboard lets decode detect hazards on rs operands.
- Sits between the execute/memory stages and the register file.

Parameters:
- NUM_REGS, 32, number of architectural registers
- XLEN, 32, data width
- RSLEN, 5, register address width (clog2 of NUM_REGS)
- LQ_DEPTH, 2, long-result FIFO depth (power of 2, ≥2)
- STARVE_LIMIT, 4, cycles a non-empty FIFO may wait before ALU is back-pressured

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alu_valid  in  1  ALU result valid
- alu_ready  out  1  ALU result accepted this cycle when alu_valid & alu_ready
- alu_rd  in  RSLEN  ALU destination
- alu_data  in  XLEN  ALU result
- lng_valid  in  1  long-latency result valid
- lng_ready  out  1  FIFO not full
- lng_rd  in  RSLEN  long-latency destination
- lng_data  in  XLEN  long-latency result
- issue_lng  in  1  decode issued a long-latency op this cycle
- issue_rd  in  RSLEN  its destination
- rsa_a  in  RSLEN  decode operand A address
- rsb_a  in  RSLEN  decode operand B address
- busy_a  out  1  rsa_a has a pending long-latency write
- busy_b  out  1  rsb_a has a pending long-latency write
- wb_e  out  1  register-file write enable (registered)
- w_baddr  out  RSLEN  write address (registered)
- wb_data  out  XLEN  write data (registered)

Behaviour:
- Reset: wb_e=0, w_baddr=0, wb_data=0. FIFO emptied. Scoreboard cleared. Starve counter=0. Outputs during reset: alu_ready=1, lng_ready=1, busy_a=busy_b=0. A reset mid-operation discards all buffered and in-flight results.
- FIFO push: on lng_valid & lng_ready. lng_ready = (count < LQ_DEPTH), with no same-cycle push-when-full even if a pop occurs.
- Pointers wrap modulo LQ_DEPTH. Count width is clog2(LQ_DEPTH)+1.
- No bypass: a pushed entry is eligible to pop the next cycle at the earliest.
- Arbitration each cycle, with forced = (fifo non-empty) & (starve_cnt == STARVE_LIMIT):
  - alu_ready = ~forced.
  - If alu_valid & alu_ready, the ALU is selected.
  - Otherwise, if the FIFO is non-empty, the FIFO head is selected and popped.
  - Otherwise nothing is selected.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, each cycle the FIFO is non-empty and not popped.
  - Clears on a pop or when the FIFO is empty.
- Write port: a selection in cycle N produces wb_e=1, w_baddr=rd, wb_data=data in cycle N+1.
  - A selected result with rd==0 is consumed (FIFO popped, ALU accepted), but wb_e=0 in N+1.
  - With no selection, wb_e=0 in N+1. w_baddr and wb_data hold their previous values.
- Latency:
  - ALU result: 1 cycle.
  - Long-latency result: minimum 2 cycles from push to wb_e.
- Scoreboard (NUM_REGS bits, bit 0 hardwired 0):
  - Set: issue_lng & issue_rd≠0 sets pend[issue_rd].
  - Clear: a FIFO pop with rd≠0 clears pend[rd].
  - If set and clear hit the same register in the same cycle, set wins (new issue supersedes).
  - busy_a = pend[rsa_a] and busy_b = pend[rsb_a], combinational, reflecting the registered state only (no same-cycle set/clear forwarding).
- Protocol rules (checked by assertions, not handled in RTL):
  - An ALU write to a register with pend=1 is illegal; decode must stall on busy.
  - Upstream holds alu_* stable while alu_valid & ~alu_ready.
  - Upstream holds lng_* stable while lng_valid & ~lng_ready.

Decomposition:
- Shared package/defs: XLEN, RSLEN, the ZWord zero constant, the reset-enable polarity constant, and a wb_req record {rd, data}.
- One sub-module: wb_fifo, a parameterised synchronous FIFO (depth LQ_DEPTH, width RSLEN+XLEN, push/pop/full/empty/count).
- Arbitration, starve counter, scoreboard and output register stay in the top.

Test Plan:
- ALU alone: alu_valid=1, rd=5, data=0x1234 in cycle 10 -> wb_e=1, w_baddr=5, wb_data=0x1234 in cycle 11. alu_ready stays 1.
- Long path and scoreboard:
  - issue_lng rd=7 -> busy_a=1 for rsa_a=7 from the next cycle.
  - Then push lng rd=7, data=0xDEAD with no ALU traffic -> wb_e in push+2, and busy clears the cycle after the pop.
- Collision: ALU rd=3 and FIFO head rd=9 both present -> rd=3 written first, rd=9 the following cycle. FIFO count decrements only on the second cycle.
- Starvation: FIFO holds 1 entry, alu_valid=1 continuously -> after 4 deferred cycles alu_ready=0 for 1 cycle, the FIFO entry is written, then alu_ready returns to 1.
- Full and rd=0:
  - Push 2 entries, the first with rd=0, while the ALU blocks -> lng_ready=0 and a third push is refused.
  - When drained, the rd=0 entry produces wb_e=0 and the rd≠0 entry produces wb_e=1.
- Reset mid-operation: with FIFO=2 entries and pend[4]=1, assert rst for 1 cycle -> next cycle wb_e=0, FIFO empty, busy_*=0, alu_ready=lng_ready=1.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared widths, constants and the write-back request record for the register-file write arbiter.
package wb_arbiter_pkg;

  localparam int XLEN  = 32;
  localparam int RSLEN = 5;

  localparam logic            RST_ACTIVE = 1'b1;
  localparam logic [XLEN-1:0] ZWord      = '0;

  typedef struct packed {
    logic [RSLEN-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_req_t;

  localparam int WB_REQ_W = $bits(wb_req_t);

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of ALU/long-result handshakes, decode scoreboard lookups and the register-file write port.
interface wb_arbiter_if;
  import wb_arbiter_pkg::*;

  logic             alu_valid;
  logic             alu_ready;
  logic [RSLEN-1:0] alu_rd;
  logic [XLEN-1:0]  alu_data;

  logic             lng_valid;
  logic             lng_ready;
  logic [RSLEN-1:0] lng_rd;
  logic [XLEN-1:0]  lng_data;

  logic             issue_lng;
  logic [RSLEN-1:0] issue_rd;
  logic [RSLEN-1:0] rsa_a;
  logic [RSLEN-1:0] rsb_a;
  logic             busy_a;
  logic             busy_b;

  logic             wb_e;
  logic [RSLEN-1:0] w_baddr;
  logic [XLEN-1:0]  wb_data;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lng_valid, lng_rd, lng_data,
    input  issue_lng, issue_rd, rsa_a, rsb_a,
    output alu_ready, lng_ready, busy_a, busy_b,
    output wb_e, w_baddr, wb_data
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lng_valid, lng_rd, lng_data,
    output issue_lng, issue_rd, rsa_a, rsb_a,
    input  alu_ready, lng_ready, busy_a, busy_b,
    input  wb_e, w_baddr, wb_data
  );

endinterface

// File: rtl/wb_arbiter_fifo.sv
// Synchronous FIFO with registered head (no write-through); push refused when full, pop ignored when empty.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = WB_REQ_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_dat,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head_dat,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign w_push     = i_push & ~o_full;
  assign w_pop      = i_pop & ~o_empty;
  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU and buffered long-latency results onto the single register-file write port (1-cycle registered),
// keeps the pending-register scoreboard; ALU is back-pressured only when the FIFO head has starved STARVE_LIMIT cycles.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int LQ_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);

  localparam int              CNT_W  = $clog2(LQ_DEPTH) + 1;
  localparam int              SC_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

  logic                w_in_rst;
  wb_req_t             w_push_req;
  wb_req_t             w_head;
  wb_req_t             w_sel_req;
  logic                w_full;
  logic                w_empty;
  logic [CNT_W-1:0]    w_count;
  logic                w_push;
  logic                w_pop;
  logic                w_forced;
  logic                w_alu_rdy;
  logic                w_lng_rdy;
  logic                w_alu_sel;
  logic                w_sel;
  logic [NUM_REGS-1:0] w_pend_nxt;

  logic [SC_W-1:0]     r_starve;
  logic [NUM_REGS-1:0] r_pend;
  logic                r_wb_e;
  logic [RSLEN-1:0]    r_wb_addr;
  logic [XLEN-1:0]     r_wb_data;

  assign w_in_rst   = (rst == RST_ACTIVE);
  assign w_push_req = '{rd: bus.lng_rd, data: bus.lng_data};

  wb_fifo #(
    .DEPTH (LQ_DEPTH),
    .WIDTH (WB_REQ_W)
  ) u_lq (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (w_push_req),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count)
  );

  always_comb begin
    w_forced  = ~w_empty & (r_starve == SC_MAX);
    w_alu_rdy = ~w_forced;
    w_lng_rdy = (w_count < CNT_W'(LQ_DEPTH));
    w_alu_sel = bus.alu_valid & w_alu_rdy;
    w_pop     = ~w_alu_sel & ~w_empty;
    w_sel     = w_alu_sel | w_pop;
    w_sel_req = w_alu_sel ? '{rd: bus.alu_rd, data: bus.alu_data} : w_head;
    w_push    = bus.lng_valid & ~w_full;
  end

  // A new issue to the same register supersedes the retiring write.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_pop && (w_head.rd != '0)) begin
      w_pend_nxt[w_head.rd] = 1'b0;
    end
    if (bus.issue_lng && (bus.issue_rd != '0)) begin
      w_pend_nxt[bus.issue_rd] = 1'b1;
    end
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_in_rst) begin
      r_starve <= '0;
      r_pend   <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_empty || w_pop) begin
        r_starve <= '0;
      end else if (r_starve != SC_MAX) begin
        r_starve <= r_starve + 1'b1;
      end
    end
  end

  // Writes to x0 are consumed but never reach the register file.
  always_ff @(posedge clk) begin
    if (w_in_rst) begin
      r_wb_e    <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= ZWord;
    end else begin
      r_wb_e <= w_sel & (w_sel_req.rd != '0);
      if (w_sel) begin
        r_wb_addr <= w_sel_req.rd;
        r_wb_data <= w_sel_req.data;
      end
    end
  end

  assign bus.alu_ready = w_alu_rdy | w_in_rst;
  assign bus.lng_ready = w_lng_rdy | w_in_rst;
  assign bus.busy_a    = r_pend[bus.rsa_a] & ~w_in_rst;
  assign bus.busy_b    = r_pend[bus.rsb_a] & ~w_in_rst;
  assign bus.wb_e      = r_wb_e;
  assign bus.w_baddr   = r_wb_addr;
  assign bus.wb_data   = r_wb_data;

  a_alu_no_pend: assert property (@(posedge clk) disable iff (w_in_rst)
    (w_alu_sel && (bus.alu_rd != '0)) |-> !r_pend[bus.alu_rd]);

  a_alu_hold: assert property (@(posedge clk) disable iff (w_in_rst)
    (bus.alu_valid && !w_alu_rdy) |=> (bus.alu_valid && $stable(bus.alu_rd) && $stable(bus.alu_data)));

  a_lng_hold: assert property (@(posedge clk) disable iff (w_in_rst)
    (bus.lng_valid && !w_lng_rdy) |=> (bus.lng_valid && $stable(bus.lng_rd) && $stable(bus.lng_data)));

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench: directed cycle table, hand sequences (full/x0, reset), then random traffic vs a queue model.
module tb_wb_arbiter;

  localparam int LQ_DEPTH     = 2;
  localparam int STARVE_LIMIT = 4;
  localparam int NR           = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_arbiter_if bus ();

  wb_arbiter #(
    .NUM_REGS     (32),
    .LQ_DEPTH     (LQ_DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic        av;  logic [4:0] ard; logic [31:0] ad;
    logic        lv;  logic [4:0] lrd; logic [31:0] ld;
    logic        iv;  logic [4:0] ird;
    logic [4:0]  rsa;
    logic        e_ar; logic e_lr; logic e_busy;
    logic        e_we; logic [4:0] e_wa; logic [31:0] e_wd;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  vec_t vt[$];

  // reference model state
  ent_t        q[$];
  bit   [31:0] m_pend;
  int          m_starve;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  function automatic vec_t mk(
    logic av, logic [4:0] ard, logic [31:0] ad,
    logic lv, logic [4:0] lrd, logic [31:0] ld,
    logic iv, logic [4:0] ird, logic [4:0] rsa,
    logic ear, logic elr, logic eb, logic ewe, logic [4:0] ewa, logic [31:0] ewd);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad;
    v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.iv = iv; v.ird = ird; v.rsa = rsa;
    v.e_ar = ear; v.e_lr = elr; v.e_busy = eb;
    v.e_we = ewe; v.e_wa = ewa; v.e_wd = ewd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_wb(input string nm, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    chk({nm, "_wb_e"}, 32'(bus.wb_e), 32'(we));
    if (we) begin
      chk({nm, "_addr"}, 32'(bus.w_baddr), 32'(wa));
      chk({nm, "_data"}, bus.wb_data, wd);
    end
  endtask

  task automatic set_in(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                        input logic iv, input logic [4:0] ird,
                        input logic [4:0] rsa, input logic [4:0] rsb);
    bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
    bus.lng_valid = lv; bus.lng_rd = lrd; bus.lng_data = ld;
    bus.issue_lng = iv; bus.issue_rd = ird;
    bus.rsa_a = rsa; bus.rsb_a = rsb;
  endtask

  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input logic iv, input logic [4:0] ird, input logic [4:0] rsa);
    @(posedge clk); #1;
    set_in(av, ard, ad, lv, lrd, ld, iv, ird, rsa, rsa);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    logic c_av, c_lv, c_iv, c_forced, c_can_push, c_nonempty, c_popped, c_sel;
    logic c_alu_hold, c_lng_hold;
    logic [4:0]  c_ard, c_lrd, c_ird, c_rsa, c_rsb, c_srd;
    logic [31:0] c_ad, c_ld, c_sd;
    ent_t e;

    // idle, rsa
    vt.push_back(mk(1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,    1'b0,5'd0,5'd0, 1'b1,1'b1,1'b0, 1'b0,5'd0,32'h0));
    vt.push_back(mk(1'b1,5'd5,32'h1234, 1'b0,5'd0,32'h0,    1'b0,5'd0,5'd7, 1'b1,1'b1,1'b0, 1'b0,5'd0,32'h0));
    vt.push_back(mk(1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,    1'b1,5'd7,5'd7, 1'b1,1'b1,1'b0, 1'b1,5'd5,32'h1234));
    vt.push_back(mk(1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,    1'b0,5'd0,5'd7, 1'b1,1'b1,1'b1, 1'b0,5'd0,32'h0));
    vt.push_back(mk(1'b0,5'd0,32'h0,    1'b1,5'd7,32'hDEAD, 1'b0,5'd0,5'd7, 1'b1,1'b1,1'b1, 1'b0,5'd0,32'h0));
    vt.push_back(mk(1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,    1'b0,5'd0,5'd7, 1'b1,1'b1,1'b1, 1'b0,5'd0,32'h0));
    vt.push_back(mk(1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,    1'b0,5'd0,5'd7, 1'b1,1'b1,1'b0, 1'b1,5'd7,32'hDEAD));
    // collision: ALU rd3 vs FIFO head rd9
    vt.push_back(mk(1'b0,5'd0,32'h0,    1'b1,5'd9,32'h99,   1'b0,5'd0,5'd0, 1'b1,1'b1,1'b0, 1'b0,5'd0,32'h0));
    vt.push_back(mk(1'b1,5'd3,32'h33,   1'b1,5'd10,32'hAA,  1'b0,5'd0,5'd0, 1'b1,1'b1,1'b0, 1'b0,5'd0,32'h0));
    vt.push_back(mk(1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,    1'b0,5'd0,5'd0, 1'b1,1'b0,1'b0, 1'b1,5'd3,32'h33));
    vt.push_back(mk(1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,    1'b0,5'd0,5'd0, 1'b1,1'b1,1'b0, 1'b1,5'd9,32'h99));
    vt.push_back(mk(1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,    1'b0,5'd0,5'd0, 1'b1,1'b1,1'b0, 1'b1,5'd10,32'hAA));
    // starvation: one FIFO entry vs continuous ALU traffic
    vt.push_back(mk(1'b0,5'd0,32'h0,    1'b1,5'd11,32'hBB,  1'b0,5'd0,5'd0, 1'b1,1'b1,1'b0, 1'b0,5'd0,32'h0));
    vt.push_back(mk(1'b1,5'd1,32'h101,  1'b0,5'd0,32'h0,    1'b0,5'd0,5'd0, 1'b1,1'b1,1'b0, 1'b0,5'd0,32'h0));
    vt.push_back(mk(1'b1,5'd1,32'h102,  1'b0,5'd0,32'h0,    1'b0,5'd0,5'd0, 1'b1,1'b1,1'b0, 1'b1,5'd1,32'h101));
    vt.push_back(mk(1'b1,5'd1,32'h103,  1'b0,5'd0,32'h0,    1'b0,5'd0,5'd0, 1'b1,1'b1,1'b0, 1'b1,5'd1,32'h102));
    vt.push_back(mk(1'b1,5'd1,32'h104,  1'b0,5'd0,32'h0,    1'b0,5'd0,5'd0, 1'b1,1'b1,1'b0, 1'b1,5'd1,32'h103));
    vt.push_back(mk(1'b1,5'd1,32'h105,  1'b0,5'd0,32'h0,    1'b0,5'd0,5'd0, 1'b0,1'b1,1'b0, 1'b1,5'd1,32'h104));
    vt.push_back(mk(1'b1,5'd1,32'h105,  1'b0,5'd0,32'h0,    1'b0,5'd0,5'd0, 1'b1,1'b1,1'b0, 1'b1,5'd11,32'hBB));
    vt.push_back(mk(1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,    1'b0,5'd0,5'd0, 1'b1,1'b1,1'b0, 1'b1,5'd1,32'h105));
    vt.push_back(mk(1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,    1'b0,5'd0,5'd0, 1'b1,1'b1,1'b0, 1'b0,5'd0,32'h0));

    // reset
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    chk("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
    chk("rst_lng_ready", 32'(bus.lng_ready), 32'd1);
    chk("rst_busy_a", 32'(bus.busy_a), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wb_e", 32'(bus.wb_e), 32'd0);
    chk("rst_addr", 32'(bus.w_baddr), 32'd0);
    chk("rst_data", bus.wb_data, 32'd0);

    foreach (vt[i]) begin
      step(vt[i].av, vt[i].ard, vt[i].ad, vt[i].lv, vt[i].lrd, vt[i].ld, vt[i].iv, vt[i].ird, vt[i].rsa);
      chk($sformatf("vec%0d_alu_ready", i), 32'(bus.alu_ready), 32'(vt[i].e_ar));
      chk($sformatf("vec%0d_lng_ready", i), 32'(bus.lng_ready), 32'(vt[i].e_lr));
      chk($sformatf("vec%0d_busy_a", i), 32'(bus.busy_a), 32'(vt[i].e_busy));
      chk($sformatf("vec%0d_busy_b", i), 32'(bus.busy_b), 32'(vt[i].e_busy));
      chk_wb($sformatf("vec%0d", i), vt[i].e_we, vt[i].e_wa, vt[i].e_wd);
    end

    // full FIFO, third push refused and held, x0 entry consumed silently
    step(1'b1, 5'd2, 32'hA0, 1'b1, 5'd0,  32'h50, 1'b0, 5'd0, 5'd0);
    chk("full_a_lng_ready", 32'(bus.lng_ready), 32'd1);
    step(1'b1, 5'd2, 32'hA1, 1'b1, 5'd12, 32'h60, 1'b0, 5'd0, 5'd0);
    chk("full_b_lng_ready", 32'(bus.lng_ready), 32'd1);
    chk_wb("full_b", 1'b1, 5'd2, 32'hA0);
    step(1'b1, 5'd2, 32'hA2, 1'b1, 5'd13, 32'h70, 1'b0, 5'd0, 5'd0);
    chk("full_c_refused", 32'(bus.lng_ready), 32'd0);
    chk("full_c_alu_ready", 32'(bus.alu_ready), 32'd1);
    chk_wb("full_c", 1'b1, 5'd2, 32'hA1);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'h70, 1'b0, 5'd0, 5'd0);
    chk("full_d_refused", 32'(bus.lng_ready), 32'd0);
    chk_wb("full_d", 1'b1, 5'd2, 32'hA2);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'h70, 1'b0, 5'd0, 5'd0);
    chk("full_e_lng_ready", 32'(bus.lng_ready), 32'd1);
    chk("full_e_rd0_no_write", 32'(bus.wb_e), 32'd0);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    chk_wb("full_f", 1'b1, 5'd12, 32'h60);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    chk_wb("full_g", 1'b1, 5'd13, 32'h70);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    chk("full_h_wb_e", 32'(bus.wb_e), 32'd0);

    // reset with two buffered entries and pend[4] set
    step(1'b1, 5'd2, 32'hB0, 1'b1, 5'd20, 32'h1, 1'b1, 5'd4, 5'd4);
    step(1'b1, 5'd2, 32'hB1, 1'b1, 5'd21, 32'h2, 1'b0, 5'd0, 5'd4);
    chk("mrst_pre_busy_a", 32'(bus.busy_a), 32'd1);
    step(1'b1, 5'd2, 32'hB2, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4);
    chk("mrst_pre_full", 32'(bus.lng_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd4);
    @(negedge clk);
    chk("mrst_in_alu_ready", 32'(bus.alu_ready), 32'd1);
    chk("mrst_in_lng_ready", 32'(bus.lng_ready), 32'd1);
    chk("mrst_in_busy_a", 32'(bus.busy_a), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_wb_e", 32'(bus.wb_e), 32'd0);
    chk("mrst_addr", 32'(bus.w_baddr), 32'd0);
    chk("mrst_data", bus.wb_data, 32'd0);
    chk("mrst_busy_a", 32'(bus.busy_a), 32'd0);
    chk("mrst_busy_b", 32'(bus.busy_b), 32'd0);
    chk("mrst_alu_ready", 32'(bus.alu_ready), 32'd1);
    chk("mrst_lng_ready", 32'(bus.lng_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4);
      chk($sformatf("mrst_drained%0d", k), 32'(bus.wb_e), 32'd0);
    end

    // random traffic against the model
    q.delete();
    m_pend = '0; m_starve = 0; m_we = 1'b0; m_wa = '0; m_wd = '0;
    c_alu_hold = 1'b0; c_lng_hold = 1'b0;
    c_av = 1'b0; c_ard = '0; c_ad = '0; c_lv = 1'b0; c_lrd = '0; c_ld = '0;
    for (int c = 0; c < NR; c++) begin
      @(posedge clk); #1;
      if (!c_alu_hold) begin
        c_av = ($urandom_range(0, 9) < 6);
        do c_ard = 5'($urandom_range(0, 15)); while (c_ard != 5'd0 && m_pend[c_ard]);
        c_ad = $urandom();
      end
      if (!c_lng_hold) begin
        c_lv  = ($urandom_range(0, 9) < 4);
        c_lrd = 5'($urandom_range(0, 7));
        c_ld  = $urandom();
      end
      c_iv  = ($urandom_range(0, 9) < 2);
      c_ird = 5'($urandom_range(0, 7));
      if (c_av && c_ird == c_ard) c_iv = 1'b0;
      c_rsa = 5'($urandom_range(0, 7));
      c_rsb = 5'($urandom_range(0, 7));
      set_in(c_av, c_ard, c_ad, c_lv, c_lrd, c_ld, c_iv, c_ird, c_rsa, c_rsb);
      @(negedge clk);

      c_forced   = (q.size() != 0) && (m_starve == STARVE_LIMIT);
      c_can_push = (q.size() < LQ_DEPTH);
      chk("rnd_alu_ready", 32'(bus.alu_ready), 32'(!c_forced));
      chk("rnd_lng_ready", 32'(bus.lng_ready), 32'(c_can_push));
      chk("rnd_busy_a", 32'(bus.busy_a), 32'(m_pend[c_rsa]));
      chk("rnd_busy_b", 32'(bus.busy_b), 32'(m_pend[c_rsb]));
      chk_wb("rnd", m_we, m_wa, m_wd);

      c_nonempty = (q.size() != 0);
      c_popped = 1'b0; c_sel = 1'b0; c_srd = '0; c_sd = '0;
      if (c_av && !c_forced) begin
        c_sel = 1'b1; c_srd = c_ard; c_sd = c_ad;
      end else if (c_nonempty) begin
        e = q.pop_front();
        c_sel = 1'b1; c_srd = e.rd; c_sd = e.data; c_popped = 1'b1;
        if (e.rd != 5'd0) m_pend[e.rd] = 1'b0;
      end
      if (c_lv && c_can_push) q.push_back('{rd: c_lrd, data: c_ld});
      if (c_iv && c_ird != 5'd0) m_pend[c_ird] = 1'b1;
      if (!c_nonempty || c_popped) m_starve = 0;
      else if (m_starve < STARVE_LIMIT) m_starve++;
      m_we = c_sel && (c_srd != 5'd0);
      if (c_sel) begin m_wa = c_srd; m_wd = c_sd; end
      c_alu_hold = c_av && c_forced;
      c_lng_hold = c_lv && !c_can_push;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
